// File: rtl/pc_next_ras.sv
// Next-PC selection with a circular return-address stack serving `jr $ra`.
// Optional RAS_CHECK_EN: cross-check popped return address against rs_val.
module pc_next_ras #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              pc,
  input  logic [31:0]              imm,
  input  logic [25:0]              jaddr,
  input  logic                     branch_taken,
  input  logic                     jump,
  input  logic                     jal,
  input  logic                     jr,
  input  logic                     jr_is_ra,
  input  logic [31:0]              rs_val,
  input  logic                     stall,
  output logic [31:0]              pc_next,
  output logic [$clog2(DEPTH):0]   ras_depth,
  output logic                     ras_overflow,
  output logic                     ras_underflow,
  output logic                     ras_mismatch
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;

  logic [31:0]   entry_reg [DEPTH];
  logic [PW-1:0] top_reg;
  logic [DW-1:0] depth_reg;
  logic          overflow_reg;
  logic          underflow_reg;

  logic [31:0]   pc4;
  logic [31:0]   branch_target;
  logic [31:0]   jump_target;
  logic [31:0]   ras_top;
  logic [PW-1:0] top_inc;
  logic          ras_empty;
  logic          ras_full;
  logic          do_push;
  logic          do_pop;
  logic          do_underflow;
  logic          mismatch;

  assign pc4           = pc + 32'd4;
  assign branch_target = pc4 + (imm << 2);
  assign jump_target   = {pc4[31:28], jaddr, 2'b00};
  assign ras_top       = entry_reg[top_reg];
  assign top_inc       = top_reg + PW'(1);
  assign ras_empty     = (depth_reg == '0);
  assign ras_full      = (depth_reg == DW'(DEPTH));

  // jr outranks jal, so a simultaneous jr+jal never pushes.
  assign do_push      = !reset && !stall && !jr && jal;
  assign do_pop       = !reset && !stall && jr && jr_is_ra && !ras_empty;
  assign do_underflow = !reset && !stall && jr && jr_is_ra && ras_empty;

`ifdef RAS_CHECK_EN
  assign mismatch = do_pop && (ras_top != rs_val);
`else
  assign mismatch = 1'b0;
`endif

  always_comb begin
    pc_next = pc4;
    if (reset) begin
      pc_next = RESET_PC;
    end else if (stall) begin
      pc_next = pc;
    end else if (jr) begin
      // Register value is the fallback for empty stack, non-$ra source, or a detected mismatch.
      pc_next = (do_pop && !mismatch) ? ras_top : rs_val;
    end else if (jump || jal) begin
      pc_next = jump_target;
    end else if (branch_taken) begin
      pc_next = branch_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_reg[i] <= '0;
      end
      top_reg       <= '0;
      depth_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (do_push) begin
        // When full, top_inc lands on the oldest entry, which is overwritten.
        top_reg            <= top_inc;
        entry_reg[top_inc] <= pc4;
        if (ras_full) begin
          overflow_reg <= 1'b1;
        end else begin
          depth_reg <= depth_reg + DW'(1);
        end
      end else if (do_pop) begin
        top_reg   <= top_reg - PW'(1);
        depth_reg <= depth_reg - DW'(1);
      end
      if (do_underflow) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign ras_depth     = depth_reg;
  assign ras_overflow  = overflow_reg;
  assign ras_underflow = underflow_reg;
  assign ras_mismatch  = mismatch;

endmodule

// File: tb/tb_pc_next_ras.sv
// Directed bench for pc_next_ras: vector table for PC selection, sequences for the stack.
module tb_pc_next_ras;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, imm, rs_val;
  logic [25:0] jaddr;
  logic        branch_taken, jump, jal, jr, jr_is_ra, stall;
  logic [31:0] pc_next;
  logic [2:0]  ras_depth;
  logic        ras_overflow, ras_underflow, ras_mismatch;

  int errors = 0;
  int checks = 0;

`ifdef RAS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  always #5 clk = ~clk;

  pc_next_ras #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .pc(pc), .imm(imm), .jaddr(jaddr),
    .branch_taken(branch_taken), .jump(jump), .jal(jal), .jr(jr),
    .jr_is_ra(jr_is_ra), .rs_val(rs_val), .stall(stall),
    .pc_next(pc_next), .ras_depth(ras_depth), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow), .ras_mismatch(ras_mismatch)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [25:0] jaddr;
    logic        br, jmp, jrr, stl;
    logic [31:0] rs;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic idle();
    imm = '0; jaddr = '0; rs_val = '0;
    branch_taken = 0; jump = 0; jal = 0; jr = 0; jr_is_ra = 0; stall = 0;
  endtask

  task automatic do_jal(input logic [31:0] p, input string name);
    logic [31:0] p4;
    @(negedge clk);
    idle();
    pc = p; jal = 1; jaddr = 26'h100;
    p4 = p + 32'd4;
    #1 chk({name, " pc_next"}, pc_next, {p4[31:28], 26'h100, 2'b00});
    @(posedge clk); #1;
    idle();
  endtask

  task automatic do_ret(input logic [31:0] p, input logic [31:0] rs,
                        input logic [31:0] exp, input string name);
    @(negedge clk);
    idle();
    pc = p; jr = 1; jr_is_ra = 1; rs_val = rs;
    #1 chk({name, " pc_next"}, pc_next, exp);
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    vecs[0] = '{32'h0000_0040, 32'h0,         26'h0,       0, 0, 0, 0, 32'h0,      32'h0000_0044};
    vecs[1] = '{32'h0000_0100, 32'hFFFF_FFFE, 26'h0,       1, 0, 0, 0, 32'h0,      32'h0000_00FC};
    vecs[2] = '{32'h1000_0000, 32'hFFFF_FFFE, 26'h10,      1, 1, 0, 0, 32'h0,      32'h1000_0040};
    vecs[3] = '{32'h0000_0500, 32'h0,         26'h10,      1, 1, 1, 0, 32'h1234,   32'h0000_1234};
    vecs[4] = '{32'h0000_0300, 32'h0,         26'h10,      1, 1, 1, 1, 32'h1234,   32'h0000_0300};
    vecs[5] = '{32'hFFFF_FFFC, 32'h0,         26'h0,       0, 0, 0, 0, 32'h0,      32'h0000_0000};
    vecs[6] = '{32'h0000_0000, 32'h1,         26'h0,       1, 0, 0, 0, 32'h0,      32'h0000_0008};
    vecs[7] = '{32'hF000_0000, 32'h0,         26'h3FF_FFFF, 0, 1, 0, 0, 32'h0,     32'hFFFF_FFFC};
    vecs[8] = '{32'h0000_0800, 32'h7,         26'h0,       0, 0, 0, 0, 32'h0,      32'h0000_0804};

    idle();
    reset = 1; pc = 32'h40;
    #1;
    chk("reset pc_next", pc_next, 32'h0);
    chk("reset depth", 32'(ras_depth), 32'd0);
    chk("reset flags", {29'b0, ras_overflow, ras_underflow, ras_mismatch}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      idle();
      pc = vecs[i].pc; imm = vecs[i].imm; jaddr = vecs[i].jaddr;
      branch_taken = vecs[i].br; jump = vecs[i].jmp; jr = vecs[i].jrr;
      stall = vecs[i].stl; rs_val = vecs[i].rs;
      #1 chk($sformatf("vec%0d pc_next", i), pc_next, vecs[i].exp_pc);
    end
    @(posedge clk); #1;
    idle();
    chk("vectors leave depth 0", 32'(ras_depth), 32'd0);
    chk("vectors leave flags 0", {30'b0, ras_overflow, ras_underflow}, 32'd0);

    // Single call/return pair.
    do_jal(32'h200, "jal 0x200");
    chk("depth after jal", 32'(ras_depth), 32'd1);
    do_ret(32'h480, 32'h204, 32'h204, "ret 0x204");
    chk("depth after ret", 32'(ras_depth), 32'd0);

    // Overflow then drain; pops prove the stack (not rs_val) is used when checking is off.
    do_jal(32'h10, "jal1");
    do_jal(32'h20, "jal2");
    do_jal(32'h30, "jal3");
    do_jal(32'h40, "jal4");
    chk("overflow before 5th push", 32'(ras_overflow), 32'd0);
    do_jal(32'h50, "jal5");
    chk("depth full", 32'(ras_depth), 32'd4);
    chk("overflow set", 32'(ras_overflow), 32'd1);
    do_ret(32'h900, CHK ? 32'h54 : 32'hDEAD_0000, 32'h54, "ret1");
    do_ret(32'h900, CHK ? 32'h44 : 32'hDEAD_0000, 32'h44, "ret2");
    do_ret(32'h900, CHK ? 32'h34 : 32'hDEAD_0000, 32'h34, "ret3");
    chk("underflow before empty pop", 32'(ras_underflow), 32'd0);
    do_ret(32'h900, CHK ? 32'h24 : 32'hDEAD_0000, 32'h24, "ret4");
    chk("depth drained", 32'(ras_depth), 32'd0);
    do_ret(32'h900, 32'h14, 32'h14, "ret empty");
    chk("underflow set", 32'(ras_underflow), 32'd1);
    chk("depth stays 0", 32'(ras_depth), 32'd0);
    chk("overflow sticky", 32'(ras_overflow), 32'd1);

    // Stall blocks the push.
    @(negedge clk);
    idle();
    pc = 32'h300; jal = 1; stall = 1; jaddr = 26'h100;
    #1 chk("stall jal pc_next", pc_next, 32'h300);
    @(posedge clk); #1;
    idle();
    chk("stall depth unchanged", 32'(ras_depth), 32'd0);

    // Asynchronous reset between edges.
    do_jal(32'h60, "jalA");
    do_jal(32'h70, "jalB");
    do_jal(32'h80, "jalC");
    chk("depth 3 built", 32'(ras_depth), 32'd3);
    @(negedge clk);
    #1 reset = 1;
    #1;
    chk("async reset depth", 32'(ras_depth), 32'd0);
    chk("async reset flags", {30'b0, ras_overflow, ras_underflow}, 32'd0);
    chk("async reset pc_next", pc_next, 32'h0);
    #1 reset = 0;
    do_ret(32'h900, 32'h99, 32'h99, "ret after reset");
    chk("underflow after reset pop", 32'(ras_underflow), 32'd1);

    // Return address disagreeing with the register file.
    do_jal(32'h20, "jal 0x20");
    @(negedge clk);
    idle();
    pc = 32'h900; jr = 1; jr_is_ra = 1; rs_val = 32'h80;
    #1;
    chk("mismatch pc_next", pc_next, CHK ? 32'h80 : 32'h24);
    chk("mismatch flag", 32'(ras_mismatch), CHK ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    idle();
    chk("depth after mismatch pop", 32'(ras_depth), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_next_ras.md
Name: pc_next_ras

Overview:
Next-PC stage directly upstream of pcBlock. It drives pcBlock.in each cycle and takes pcBlock.salida back as its current-PC input. It selects among sequential, branch, jump and jump-register targets. It contains a circular hardware return-address stack (RAS) so that `jr $ra` returns are served from the stack, with the register-file value used as fallback.

Parameters:
DEPTH, 4, RAS entries (power of two, >=2)
RESET_PC, 32'h0000_0000, value driven on pc_next while reset is high

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
pc  input  32  current PC, from pcBlock.salida
imm  input  32  sign-extended branch offset, in words
jaddr  input  26  J-type target field
branch_taken  input  1  branch resolved taken (branch & zero)
jump  input  1  j instruction
jal  input  1  jal instruction
jr  input  1  jr instruction
jr_is_ra  input  1  jr source register is $31
rs_val  input  32  register-file value of rs
stall  input  1  hold PC; no RAS update
pc_next  output  32  next PC, to pcBlock.in
ras_depth  output  $clog2(DEPTH)+1  valid RAS entries
ras_overflow  output  1  sticky: push occurred while full
ras_underflow  output  1  sticky: pop occurred while empty
ras_mismatch  output  1  see Optional Feature

Behaviour:
- Reset (asynchronous, effective immediately): pc_next=RESET_PC, ras_depth=0, top pointer=0, all entries 0, sticky flags 0, ras_mismatch=0.
- pc_next is combinational (same cycle as inputs). RAS state and flags update on the rising clk edge.
- Arithmetic is modulo 2^32 with carries discarded:
  - pc4 = pc+4
  - branch target = pc4+(imm<<2)
  - jump target = {pc4[31:28], jaddr, 2'b00}
- Priority: reset > stall > jr > jump|jal > branch_taken > sequential.
  - stall: pc_next=pc; no push, no pop, flags unchanged.
  - jr with jr_is_ra=0: pc_next=rs_val; no pop.
  - jr with jr_is_ra=1 and depth>0: pc_next=entry[top]. At the edge: pop, top=top-1 mod DEPTH, depth-1.
  - jr with jr_is_ra=1 and depth=0: pc_next=rs_val; depth stays 0; ras_underflow set at the edge.
  - jump or jal: pc_next=jump target. jal also pushes pc4 at the edge: top=top+1 mod DEPTH, entry[top]=pc4.
  - Push while depth<DEPTH: depth+1.
  - Push while depth=DEPTH: the oldest entry is overwritten; depth stays at DEPTH; ras_overflow set.
  - jr together with jal: jr wins, no push (jalr is not supported).
  - jump together with jal: treated as jal.
- Sticky flags clear only on reset.
- Reset asserted mid-sequence clears the stack regardless of clk.

Optional Feature:
RAS_CHECK_EN.
- Defined: on a non-empty jr_is_ra pop, compare entry[top] against rs_val.
  - If they differ: pc_next=rs_val and ras_mismatch=1 combinationally for that cycle. The pop still occurs.
  - If they match: ras_mismatch=0 and pc_next=entry[top].
- Not defined: ras_mismatch tied to 0; popped value always used.

Test Plan:
- Reset high, pc=0x40 -> pc_next=0x0, depth=0, all flags 0. Release reset, no controls -> pc_next=0x44.
- branch_taken=1, pc=0x100, imm=0xFFFFFFFE -> pc_next=0xFC. Also assert jump=1, jaddr=0x10, pc=0x10000000 -> pc_next=0x10000040 (jump priority).
- jal, pc=0x200, jaddr=0x100 -> pc_next=0x400, depth=1 after edge. Then jr=1, jr_is_ra=1, pc=0x480, rs_val=0x204 -> pc_next=0x204, depth=0 after edge.
- DEPTH=4: five jals at pc=0x10, 0x20, 0x30, 0x40, 0x50 -> depth=4, ras_overflow=1. Four returns yield 0x54, 0x44, 0x34, 0x24. A fifth return with rs_val=0x14 -> pc_next=0x14, ras_underflow=1.
- stall=1 with jal, pc=0x300 -> pc_next=0x300, depth unchanged. Build depth=3, pulse reset between edges -> depth=0 immediately.
- RAS_CHECK_EN defined: push 0x24, then jr_is_ra with rs_val=0x80 -> pc_next=0x80, ras_mismatch=1, depth decrements.
